// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier.
// Takes one shift-add step per clock for MPLIER_WIDTH clocks, independent of the
// operand values, and then presents the low RESULT_WIDTH bits of the exact
// product together with an overflow flag.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous active-high reset, has priority over start
//   start        - request pulse, accepted only when no operation is running
//   multiplicand - unsigned operand A, sampled with start
//   multiplier   - unsigned operand B, sampled with start
//   product      - low RESULT_WIDTH bits of A*B, held until the next completion
//   overflow     - full product does not fit in RESULT_WIDTH bits
//   busy         - operation in progress
//   done         - one-cycle completion pulse
module seq_multiplier #(
    parameter int unsigned MCAND_WIDTH  = 32,
    parameter int unsigned MPLIER_WIDTH = 32,
    parameter int unsigned RESULT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [MCAND_WIDTH-1:0]  multiplicand,
    input  logic [MPLIER_WIDTH-1:0] multiplier,
    output logic [RESULT_WIDTH-1:0] product,
    output logic                    overflow,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned ACC_W = MCAND_WIDTH + MPLIER_WIDTH;
    localparam int unsigned CNT_W = (MPLIER_WIDTH > 1) ? $clog2(MPLIER_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MPLIER_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              load_c;
    logic              last_c;
    logic              ovf_c;

    logic [ACC_W-1:0]        a_sh;
    logic [MPLIER_WIDTH-1:0] b_sh;
    logic [ACC_W-1:0]        acc;
    logic [CNT_W-1:0]        step;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a new request is accepted from IDLE and from DONE
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        last_c    = (step == LAST_STEP);
        case (state)
            IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shift-add datapath; A is kept at full accumulator width so no bit is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            step <= '0;
        end else if (load_c) begin
            a_sh <= ACC_W'(multiplicand);
            b_sh <= multiplier;
            acc  <= '0;
            step <= '0;
        end else if (state == RUN) begin
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            step <= step + CNT_W'(1);
        end
    end

    // Overflow exists only when the result is narrower than the full product
    generate
        if (RESULT_WIDTH < ACC_W) begin : g_ovf
            assign ovf_c = |acc[ACC_W-1:RESULT_WIDTH];
        end else begin : g_no_ovf
            assign ovf_c = 1'b0;
        end
    endgenerate

    // Registered outputs; the result is captured while the FSM sits in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            product  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= (state == DONE);
            if (state == DONE) begin
                product  <= acc[RESULT_WIDTH-1:0];
                overflow <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a 32-bit-result and a 64-bit-result
// instance share one stimulus stream; expected products come from plain A*B.
module tb_seq_multiplier;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 2; // start edge to first sample showing done

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mcand = '0;
    logic [31:0] mplier = '0;

    logic [31:0] p32;
    logic        ov32, busy32, done32;
    logic [63:0] p64;
    logic        ov64, busy64, done64;

    typedef struct {
        logic [63:0]     full;
        longint unsigned due;
    } exp_t;

    exp_t            q[$];
    exp_t            e_mon;
    int              checks = 0;
    int              errors = 0;
    longint unsigned cyc = 0;

    logic [31:0] h32 = '0;
    logic        h_ov = 1'b0;
    logic [63:0] h64 = '0;
    int          busy_n32 = 0;
    int          busy_n64 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier #(.MCAND_WIDTH(32), .MPLIER_WIDTH(32), .RESULT_WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(mcand), .multiplier(mplier),
        .product(p32), .overflow(ov32), .busy(busy32), .done(done32)
    );

    seq_multiplier #(.MCAND_WIDTH(32), .MPLIER_WIDTH(32), .RESULT_WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(mcand), .multiplier(mplier),
        .product(p64), .overflow(ov64), .busy(busy64), .done(done64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever a done pulse is seen
    always @(negedge clk) begin
        if (reset) begin
            busy_n32 = 0;
            busy_n64 = 0;
            h32      = '0;
            h_ov     = 1'b0;
            h64      = '0;
        end else begin
            if (busy32) busy_n32++;
            if (busy64) busy_n64++;
            if (done32 || done64) begin
                chk("done_has_expectation", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e_mon = q.pop_front();
                    chk("latency", 64'(cyc), 64'(e_mon.due));
                    chk("done32", 64'(done32), 64'd1);
                    chk("done64", 64'(done64), 64'd1);
                    chk("busy_at_done32", 64'(busy32), 64'd0);
                    chk("product32", 64'(p32), 64'(e_mon.full[31:0]));
                    chk("overflow32", 64'(ov32), 64'(|e_mon.full[63:32]));
                    chk("product64", p64, e_mon.full);
                    chk("overflow64", 64'(ov64), 64'd0);
                    chk("busy_cycles32", 64'(busy_n32), 64'(W));
                    chk("busy_cycles64", 64'(busy_n64), 64'(W));
                    h32  = e_mon.full[31:0];
                    h_ov = |e_mon.full[63:32];
                    h64  = e_mon.full;
                end
                busy_n32 = 0;
                busy_n64 = 0;
            end else begin
                chk("hold_product32", 64'(p32), 64'(h32));
                chk("hold_overflow32", 64'(ov32), 64'(h_ov));
                chk("hold_product64", p64, h64);
                chk("hold_overflow64", 64'(ov64), 64'd0);
            end
        end
    end

    // Called at a negedge; the following rising edge samples start
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        if (push) begin
            e.full = 64'(a) * 64'(b);
            e.due  = cyc + 64'(LAT);
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 3 * LAT && q.size() != 0; i++) @(negedge clk);
        chk("pending_timeout", 64'(q.size()), 64'd0);
        if (q.size() != 0) q.delete();
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        issue(a, b, 1'b1);
        wait_empty();
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_product32", 64'(p32), 64'd0);
        chk("rst_overflow32", 64'(ov32), 64'd0);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_done32", 64'(done32), 64'd0);
        chk("rst_product64", p64, 64'd0);
        chk("rst_busy64", 64'(busy64), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed operands: basic, zero, identity, overflow, maximum
        run_op(32'd10, 32'd100);
        run_op(32'd0, 32'd12345);
        run_op(32'd12345678, 32'd1);
        run_op(32'hFFFF_FFFF, 32'd2);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'd0, 32'd0);

        // start mid-run with other operands is ignored
        issue(32'd7, 32'd9, 1'b1);
        repeat (5) @(negedge clk);
        issue(32'd3, 32'd3, 1'b0);
        wait_empty();

        // start high while in DONE: next operation begins with no idle cycle
        issue(32'd5, 32'd6, 1'b1);
        repeat (W) @(negedge clk);
        issue(32'd11, 32'd13, 1'b1);
        wait_empty();

        // reset ten cycles into a run aborts it with no done pulse
        issue(32'd1234, 32'd5678, 1'b1);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        chk("abort_product32", 64'(p32), 64'd0);
        chk("abort_overflow32", 64'(ov32), 64'd0);
        chk("abort_busy32", 64'(busy32), 64'd0);
        chk("abort_done32", 64'(done32), 64'd0);
        chk("abort_product64", p64, 64'd0);
        chk("abort_done64", 64'(done64), 64'd0);
        reset = 1'b0;
        repeat (2 * LAT) @(negedge clk);
        run_op(32'd99, 32'd77);

        // Random operand pairs, occasionally back to back
        for (int n = 0; n < 1000; n++) begin
            issue(rnd_operand(), rnd_operand(), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat (W) @(negedge clk);
                issue(rnd_operand(), rnd_operand(), 1'b1);
                n++;
            end
            wait_empty();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
